// File: rtl/lsu_controller.sv
// ---------------------------------------------------------------------------
// lsu_controller
//
// Multi-cycle load/store sequencer between the RV32I execute stage and a
// req/ack data-memory bus. Each load or store accepted in IDLE becomes one
// bus transaction. The PC is stalled until the transaction completes, and a
// sign- or zero-extended load result is then presented for writeback.
//
// Optional build macro:
//   LSU_TIMEOUT_EN - abort a transaction that has had no bus_ack for
//                    TIMEOUT_CYCLES REQ cycles. The abort returns a zero load
//                    result and pulses bus_err for one cycle. Without the
//                    macro, REQ waits indefinitely and bus_err is tied low.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   mem_rden, mem_wren load / store strobes from decode (store has priority)
//   funct3             access width [1:0] and unsigned-load flag [2]
//   addr               effective address from the ALU
//   st_data            store data (rs2)
//   stall              hold PC and register-file write (combinational)
//   misalign           access not naturally aligned (combinational)
//   ld_data            extended load result, valid while in DONE
//   bus_req/we/addr/wdata/be   registered bus request fields
//   bus_ack, bus_rdata bus completion and read data (same cycle)
//   bus_err            one-cycle timeout pulse (LSU_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module lsu_controller #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rden,
    input  logic              mem_wren,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic              stall,
    output logic              misalign,
    output logic [31:0]       ld_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Access size encoding used internally (funct3[1:0], with 11 folded into word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic [3:0] calc_be(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0]  size,
                                               input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{data[7:0]}};
            SZ_HALF: wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] ld_extend(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic       access;
    logic [1:0] size;

    assign access   = mem_rden | mem_wren;
    assign size     = funct3[1] ? SZ_WORD : funct3[1:0];
    assign misalign = access & (((size == SZ_HALF) & addr[0]) |
                                ((size == SZ_WORD) & (|addr[1:0])));

    // -----------------------------------------------------------------------
    // State and registered bus fields
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       ld_data_q, ld_data_d;
    // Load shaping info kept from IDLE for use when read data arrives
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              uns_q, uns_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        ld_data_d   = ld_data_q;
        size_d      = size_q;
        lane_d      = lane_q;
        uns_d       = uns_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (access && !misalign) begin
                    state_d     = REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_wren;
                    bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = calc_be(size, addr[1:0]);
                    bus_wdata_d = calc_wdata(size, st_data);
                    size_d      = size;
                    lane_d      = addr[1:0];
                    uns_d       = funct3[2];
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            REQ: begin
                // Ack is checked first so an ack on the last counted cycle
                // still completes normally.
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        ld_data_d = ld_extend(bus_rdata, size_q, lane_q, uns_q);
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    ld_data_d = 32'd0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            ld_data_q   <= 32'd0;
            size_q      <= 2'd0;
            lane_q      <= 2'd0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            ld_data_q   <= ld_data_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            uns_q       <= uns_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // DONE deliberately does not stall, so the core commits and moves on.
    assign stall     = ((state_q == IDLE) & access & ~misalign) | (state_q == REQ);
    assign ld_data   = ld_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_lsu_controller.sv
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rden;
    logic        mem_wren;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        stall;
    logic        misalign;
    logic [31:0] ld_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    lsu_controller #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rden (mem_rden),
        .mem_wren (mem_wren),
        .funct3   (funct3),
        .addr     (addr),
        .st_data  (st_data),
        .stall    (stall),
        .misalign (misalign),
        .ld_data  (ld_data),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_be   (bus_be),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access: IDLE accept, optional wait cycles, ack, DONE, IDLE.
    task automatic run_access(input string tag, input logic rd_en, input logic wr_en,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int waits, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_ld);
        mem_rden = rd_en;
        mem_wren = wr_en;
        funct3   = f3;
        addr     = a;
        st_data  = sd;
        #1;
        check({tag, ".stall_idle"}, 32'(stall), 32'd1);
        check({tag, ".misalign"}, 32'(misalign), 32'd0);
        step();
        check({tag, ".req"}, 32'(bus_req), 32'd1);
        check({tag, ".we"}, 32'(bus_we), 32'(wr_en));
        check({tag, ".addr"}, bus_addr, exp_addr);
        check({tag, ".be"}, 32'(bus_be), 32'(exp_be));
        if (wr_en) check({tag, ".wdata"}, bus_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            step();
            check({tag, ".req_hold"}, 32'(bus_req), 32'd1);
            check({tag, ".be_hold"}, 32'(bus_be), 32'(exp_be));
            check({tag, ".stall_req"}, 32'(stall), 32'd1);
        end
        bus_ack   = 1'b1;
        bus_rdata = rd;
        step();
        bus_ack = 1'b0;
        // In DONE with the access still presented: no stall, no new request
        check({tag, ".stall_done"}, 32'(stall), 32'd0);
        check({tag, ".req_done"}, 32'(bus_req), 32'd0);
        check({tag, ".ld"}, ld_data, exp_ld);
        check({tag, ".err"}, 32'(bus_err), 32'd0);
        step();
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        check({tag, ".req_after"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        st_data   = 32'd0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        #2;
        check("rst.req", 32'(bus_req), 32'd0);
        check("rst.be", 32'(bus_be), 32'd0);
        check("rst.addr", bus_addr, 32'd0);
        check("rst.wdata", bus_wdata, 32'd0);
        check("rst.ld", ld_data, 32'd0);
        check("rst.err", 32'(bus_err), 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        step();
        step();
        rst = 1'b0;

        //          tag     rd    wr    f3      addr        st_data       rdata         w   bus_addr     be       wdata         ld
        run_access("lb",   1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF_1234, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFF_FF80);
        run_access("lhu",  1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h8001_7FFF, 3, 32'h100, 4'b1100, 32'h0,        32'h0000_8001);
        run_access("sb",   1'b0, 1'b1, 3'b000, 32'h201, 32'hDEAD_BEA5, 32'h0,        0, 32'h200, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001);
        run_access("lh",   1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h1234_8000, 1, 32'h100, 4'b0011, 32'h0,        32'hFFFF_8000);
        run_access("lbu",  1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h80FF_1234, 0, 32'h100, 4'b0100, 32'h0,        32'h0000_00FF);
        run_access("sh",   1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 32'h0,        2, 32'h100, 4'b1100, 32'hBEEF_BEEF, 32'h0000_00FF);
        run_access("lw",   1'b1, 1'b0, 3'b010, 32'h044, 32'h0,        32'hCAFE_F00D, 0, 32'h044, 4'b1111, 32'h0,        32'hCAFE_F00D);
        run_access("sw11", 1'b1, 1'b1, 3'b011, 32'h048, 32'h1234_5678, 32'h0,        0, 32'h048, 4'b1111, 32'h1234_5678, 32'hCAFE_F00D);
        run_access("lb1",  1'b1, 1'b0, 3'b000, 32'h001, 32'h0,        32'h0000_7F00, 0, 32'h000, 4'b0010, 32'h0,        32'h0000_007F);

        // Misaligned word: no stall, no bus cycle
        mem_rden = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h006;
        #1;
        check("lw_mis.misalign", 32'(misalign), 32'd1);
        check("lw_mis.stall", 32'(stall), 32'd0);
        step();
        check("lw_mis.req", 32'(bus_req), 32'd0);
        step();
        check("lw_mis.req2", 32'(bus_req), 32'd0);
        // Misaligned half
        funct3 = 3'b001;
        addr   = 32'h101;
        #1;
        check("lh_mis.misalign", 32'(misalign), 32'd1);
        step();
        check("lh_mis.req", 32'(bus_req), 32'd0);
        // No access: misalign stays low even for an odd address
        mem_rden = 1'b0;
        #1;
        check("noacc.misalign", 32'(misalign), 32'd0);

        // Stray ack in IDLE is ignored
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        step();
        step();
        bus_ack = 1'b0;
        check("stray_ack.req", 32'(bus_req), 32'd0);
        check("stray_ack.stall", 32'(stall), 32'd0);
        check("stray_ack.ld", ld_data, 32'h0000_007F);

        // Reset asserted in the second REQ cycle
        mem_rden = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h080;
        step();
        step();
        check("rstreq.req_before", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstreq.req", 32'(bus_req), 32'd0);
        check("rstreq.be", 32'(bus_be), 32'd0);
        check("rstreq.addr", bus_addr, 32'd0);
        check("rstreq.ld", ld_data, 32'd0);
        rst = 1'b0;
        check("rstreq.stall_idle", 32'(stall), 32'd1);
        step();
        check("rstreq.req_again", 32'(bus_req), 32'd1);
        check("rstreq.addr_again", bus_addr, 32'h080);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1122_3344;
        step();
        bus_ack = 1'b0;
        check("rstreq.ld_after", ld_data, 32'h1122_3344);
        check("rstreq.stall_done", 32'(stall), 32'd0);
        step();
        mem_rden = 1'b0;

        // Ack on the 16th REQ cycle completes normally in either build
        run_access("ack16", 1'b1, 1'b0, 3'b010, 32'h08C, 32'h0, 32'h0BAD_CAFE, 15, 32'h08C, 4'b1111, 32'h0, 32'h0BAD_CAFE);

        // No ack for 16 REQ cycles
        mem_rden = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h090;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            check("noack.req_hold", 32'(bus_req), 32'd1);
        end
        step();
`ifdef LSU_TIMEOUT_EN
        check("tmo.err", 32'(bus_err), 32'd1);
        check("tmo.req", 32'(bus_req), 32'd0);
        check("tmo.ld", ld_data, 32'd0);
        check("tmo.stall", 32'(stall), 32'd0);
        mem_rden = 1'b0;
        step();
        check("tmo.err_pulse", 32'(bus_err), 32'd0);
        check("tmo.idle_req", 32'(bus_req), 32'd0);
        check("tmo.idle_stall", 32'(stall), 32'd0);
`else
        check("wait.req", 32'(bus_req), 32'd1);
        check("wait.stall", 32'(stall), 32'd1);
        check("wait.err", 32'(bus_err), 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h55AA_55AA;
        step();
        bus_ack = 1'b0;
        check("wait.ld", ld_data, 32'h55AA_55AA);
        check("wait.req_done", 32'(bus_req), 32'd0);
        mem_rden = 1'b0;
        step();
        check("wait.idle_stall", 32'(stall), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
